// File: rtl/snn_enc_pkg.sv
// Shared definitions for the stochastic spike encoder: FSM states, LFSR constants
// and the per-channel firing rule.
package snn_enc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } enc_state_t;

   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

   // Full-scale intensity must fire every step even when the random byte is 255
   function automatic logic spike_fire(input logic [7:0] rnd, input logic [7:0] pix);
      return (pix == 8'hFF) || (rnd < pix);
   endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR; advances one state per cycle with en high, otherwise holds.
module lfsr32
   import snn_enc_pkg::*;
#(
   parameter logic [31:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [31:0] q
);

   logic [31:0] r_state;
   logic [31:0] w_next;

   always_comb begin
      w_next = {1'b0, r_state[31:1]};
      if (r_state[0]) w_next = w_next ^ LFSR_POLY;
   end

   always_ff @(posedge clk) begin
      if (rst)     r_state <= SEED;
      else if (en) r_state <= w_next;
   end

   assign q = r_state;

endmodule

// File: rtl/spike_encoder.sv
// Rate-coded spike encoder: each accepted sample is expanded into TSTEPS steps of
// Bernoulli spikes, one LFSR byte per channel compared against the held intensity.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | in_ready high, waiting for in_valid
//   ST_RUN  | step_valid high, one encode step per cycle
//   ST_DONE | frame_done pulse for one cycle, then back to ST_IDLE
module spike_encoder
   import snn_enc_pkg::*;
#(
   parameter int          NCH    = 4,
   parameter int          TSTEPS = 16,
   parameter logic [31:0] SEED   = DEFAULT_SEED
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*NCH-1:0]   in_pixel,
   input  logic [NCH-1:0]     in_sign,
   output logic [NCH-1:0]     pos_out,
   output logic [NCH-1:0]     neg_out,
   output logic               step_valid,
   output logic               frame_done
);

   enc_state_t        r_state;
   logic [7:0]        r_step;
   logic [8*NCH-1:0]  r_pixel;
   logic [NCH-1:0]    r_sign;
   logic [NCH-1:0]    r_pos;
   logic [NCH-1:0]    r_neg;
   logic              r_step_valid;
   logic              r_frame_done;
   logic              r_in_ready;

   logic              w_transfer;
   logic              w_last;
   logic              w_lfsr_en;
   logic [31:0]       w_lfsr_q;
   logic [8*NCH-1:0]  w_pix_src;
   logic [NCH-1:0]    w_sgn_src;
   logic [NCH-1:0]    w_fire;

   assign w_transfer = in_valid && r_in_ready;
   assign w_last     = (r_step == 8'(TSTEPS - 1));

   // Spikes are registered on the edge that opens their step, so the LFSR steps on
   // exactly those TSTEPS edges: the transfer edge and every RUN edge but the last.
   assign w_lfsr_en  = w_transfer || ((r_state == ST_RUN) && !w_last);

   // Step 0 is computed on the transfer edge, before r_pixel/r_sign hold the sample
   assign w_pix_src  = w_transfer ? in_pixel : r_pixel;
   assign w_sgn_src  = w_transfer ? in_sign  : r_sign;

   lfsr32 #(.SEED(SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (w_lfsr_en),
      .q   (w_lfsr_q)
   );

   always_comb begin
      w_fire = '0;
      for (int k = 0; k < NCH; k++) begin
         w_fire[k] = spike_fire(w_lfsr_q[8*k +: 8], w_pix_src[8*k +: 8]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_step       <= '0;
         r_pixel      <= '0;
         r_sign       <= '0;
         r_pos        <= '0;
         r_neg        <= '0;
         r_step_valid <= 1'b0;
         r_frame_done <= 1'b0;
         r_in_ready   <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_frame_done <= 1'b0;
               if (w_transfer) begin
                  r_pixel      <= in_pixel;
                  r_sign       <= in_sign;
                  r_step       <= '0;
                  r_state      <= ST_RUN;
                  r_in_ready   <= 1'b0;
                  r_step_valid <= 1'b1;
                  r_pos        <= w_fire & w_sgn_src;
                  r_neg        <= w_fire & ~w_sgn_src;
               end
            end
            ST_RUN: begin
               if (w_last) begin
                  r_state      <= ST_DONE;
                  r_step_valid <= 1'b0;
                  r_pos        <= '0;
                  r_neg        <= '0;
                  r_frame_done <= 1'b1;
               end else begin
                  r_step       <= r_step + 8'd1;
                  r_pos        <= w_fire & w_sgn_src;
                  r_neg        <= w_fire & ~w_sgn_src;
               end
            end
            ST_DONE: begin
               r_frame_done <= 1'b0;
               r_state      <= ST_IDLE;
               r_in_ready   <= 1'b1;
            end
            default: begin
               r_state      <= ST_IDLE;
               r_step_valid <= 1'b0;
               r_pos        <= '0;
               r_neg        <= '0;
               r_frame_done <= 1'b0;
               r_in_ready   <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign pos_out    = r_pos;
   assign neg_out    = r_neg;
   assign step_valid = r_step_valid;
   assign frame_done = r_frame_done;

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of input channels (legal 1..4).
REQ-002 SHALL have parameter TSTEPS, default 16, meaning encode steps per accepted sample (legal 2..255).
REQ-003 SHALL have parameter SEED, default 32'hACE1_0001, meaning LFSR reset value (nonzero).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: sample offered.
REQ-007 SHALL have port in_ready, output, 1 bit: encoder can accept a sample.
REQ-008 SHALL have port in_pixel, input, 8*NCH bits: channel k intensity in bits [8k+7:8k], unsigned.
REQ-009 SHALL have port in_sign, input, NCH bits: channel k polarity (1 = positive, 0 = negative).
REQ-010 SHALL have port pos_out, output, NCH bits: one-cycle positive spike per channel.
REQ-011 SHALL have port neg_out, output, NCH bits: one-cycle negative spike per channel.
REQ-012 SHALL have port step_valid, output, 1 bit: high during each encode step.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last step.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL assert in_ready only in IDLE; a transfer occurs on a rising edge with in_valid and in_ready both high.
REQ-016 SHALL, on transfer, register in_pixel and in_sign, clear step counter to 0, and enter RUN.
REQ-017 SHALL ignore in_valid in RUN and DONE; the held sample SHALL NOT change mid-frame.
REQ-018 SHALL, in RUN, hold step_valid high for exactly TSTEPS consecutive cycles, starting the cycle after transfer.
REQ-019 SHALL, in RUN, advance the step counter by 1 per cycle and enter DONE after step TSTEPS-1.
REQ-020 SHALL, in DONE, assert frame_done for exactly one cycle, then return to IDLE; minimum sample-to-sample spacing is TSTEPS+2 cycles.
REQ-021 SHALL use a 32-bit Galois LFSR (taps x^32+x^22+x^2+x+1) that advances once per RUN cycle only and holds otherwise.
REQ-022 SHALL derive channel k random byte r_k from LFSR bits [8k+7:8k] of the current LFSR state.
REQ-023 SHALL fire channel k in a RUN cycle when r_k < pixel_k; pixel 0 SHALL never fire, and pixel 255 SHALL fire every step regardless of r_k.
REQ-024 SHALL route a firing onto pos_out[k] when the held sign is 1, otherwise onto neg_out[k]; pos_out[k] and neg_out[k] SHALL never be high together.
REQ-025 SHALL drive pos_out and neg_out from registers, and force both to 0 whenever step_valid is low.
REQ-026 SHALL NOT reseed the LFSR between frames; the sequence continues across samples.

Reset
REQ-027 SHALL, with rst high at a rising edge, set state IDLE, in_ready 1 on the following cycle, pos_out/neg_out/step_valid/frame_done 0, step counter 0, and LFSR to SEED.
REQ-028 SHALL give rst priority over a simultaneous transfer; a frame in progress at reset SHALL be discarded with no frame_done.

Structure
REQ-029 SHALL place the state enum, LFSR polynomial constant, and default SEED in shared package snn_enc_pkg.
REQ-030 SHALL implement the LFSR as the sub-module lfsr32, with ports clk, rst, en, and q[31:0].

Verification
REQ-031 SHALL cover this case: all pixels 0, signs 4'b1111 -> 16 step_valid cycles, zero spikes, then one frame_done pulse.
REQ-032 SHALL cover this case: pixels {255,255,255,255}, signs 4'b0101 -> pos_out[0] and pos_out[2] high all 16 steps, neg_out[1] and neg_out[3] high all 16 steps.
REQ-033 SHALL cover this case: in_valid held high continuously -> transfers exactly every 18 cycles, with in_ready low throughout RUN and DONE.
REQ-034 SHALL cover this case: rst asserted at step 7 of a frame -> outputs 0 next cycle, no frame_done, and the next frame's spikes identical to a post-reset golden run from SEED.
REQ-035 SHALL cover this case: pixel 128 for 64 frames -> per-channel spike count within 512 +/- 64 of 1024 steps, exact pattern matching the reference-model LFSR.
